aes_ctr_keystream_reader: RTL and testbench

- Consumer end of the AES-256 CTR keystream generator.
- Captures each 16-block (2048-bit) keystream batch on the generator's one-cycle batch pulse, then streams it out one 128-bit block per handshake over valid/ready.
- Emits exactly the mode's target block count per request: XOF 44 blocks, PRF 8 blocks.
- Flags overflow when a batch arrives before the previous one has drained.

---
 rtl/aes_ctr_pkg.sv | 29 ++
 rtl/aes_ctr_batch_buffer.sv | 26 ++
 rtl/aes_ctr_keystream_reader.sv | 128 ++++++++++++
 tb/tb_aes_ctr_keystream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared constants, mode encoding and reader state type for the AES-CTR keystream path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_ctr_pkg;

    localparam int BLOCK_W           = 128;
    localparam int BATCH_BLOCKS      = 16;
    localparam int BATCH_W           = BLOCK_W * BATCH_BLOCKS;
    localparam int XOF_TARGET_BLOCKS = 44;
    localparam int PRF_TARGET_BLOCKS = 8;
    localparam int IDX_W             = 6;
    localparam int PTR_W             = 4;

    localparam logic MODE_XOF = 1'b0;
    localparam logic MODE_PRF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Number of blocks a request emits for the given mode.
    function automatic logic [IDX_W-1:0] target_blocks(input logic m);
        return (m == MODE_PRF) ? IDX_W'(PRF_TARGET_BLOCKS) : IDX_W'(XOF_TARGET_BLOCKS);
    endfunction

endpackage

// File: rtl/aes_ctr_batch_buffer.sv
// Holds one 16-block keystream batch and presents the block chosen by sel.
// Latency: load takes effect on the next clock; block readout is combinational from the register.
// Backpressure: none; the owner decides when load may overwrite the contents.
module aes_ctr_batch_buffer
    import aes_ctr_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic [BATCH_W-1:0] batch,
    input  logic [PTR_W-1:0]   sel,
    output logic [BLOCK_W-1:0] block
);

    // Contents are meaningless until the first load, so no reset is needed.
    logic [BATCH_W-1:0] batch_q;

    // Capture the whole batch when the reader accepts it.
    always_ff @(posedge clk) begin
        if (load) begin
            batch_q <= batch;
        end
    end

    assign block = batch_q[sel * BLOCK_W +: BLOCK_W];

endmodule

// File: rtl/aes_ctr_keystream_reader.sv
// Captures generator keystream batches and streams the request's block count out over valid/ready.
// Latency: batch_valid -> ks_valid is 1 cycle; one block per handshake thereafter.
// Backpressure: ks_ready low holds the current block; a batch arriving while blocks remain is dropped and flags overflow.
module aes_ctr_keystream_reader
    import aes_ctr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [BATCH_W-1:0] batch_in,
    input  logic               batch_valid,
    output logic [BLOCK_W-1:0] ks_data,
    output logic               ks_valid,
    input  logic               ks_ready,
    output logic [IDX_W-1:0]   ks_index,
    output logic               ks_last,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    rd_state_e          state;
    logic               mode_q;
    logic [IDX_W-1:0]   count;
    logic [PTR_W-1:0]   blk_ptr;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;

    logic [IDX_W-1:0]   target;
    logic               hs;
    logic               on_last;
    logic               final_hs;
    logic               wrap_hs;
    logic               load;
    logic [BLOCK_W-1:0] blk_dat;

    assign target   = target_blocks(mode_q);
    assign hs       = valid_q && ks_ready;
    // Compare in one extra bit so count+1 can never wrap into a false match.
    assign on_last  = ({1'b0, count} + 7'd1) == {1'b0, target};
    assign final_hs = hs && on_last;
    assign wrap_hs  = hs && (blk_ptr == PTR_W'(BATCH_BLOCKS - 1));
    // A new batch is taken while waiting, or in the same cycle the last buffered block leaves
    // provided that block does not end the stream.
    assign load     = batch_valid &&
                      ((state == ST_WAIT) || ((state == ST_DRAIN) && wrap_hs && !final_hs));

    aes_ctr_batch_buffer u_buffer (
        .clk   (clk),
        .load  (load),
        .batch (batch_in),
        .sel   (blk_ptr),
        .block (blk_dat)
    );

    // Stream control: state, counters and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_XOF;
            count   <= '0;
            blk_ptr <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        count  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (batch_valid) begin
                        blk_ptr <= '0;
                        valid_q <= 1'b1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Buffer still holds undelivered blocks: the incoming batch is lost.
                    if (batch_valid && !load && !final_hs) begin
                        ovf_q <= 1'b1;
                    end
                    if (hs) begin
                        count   <= count + 6'd1;
                        blk_ptr <= blk_ptr + 4'd1;
                        if (final_hs) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_DONE;
                        end else if (wrap_hs && !batch_valid) begin
                            valid_q <= 1'b0;
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ks_valid = valid_q;
    assign ks_data  = valid_q ? blk_dat : '0;
    assign ks_index = count;
    assign ks_last  = valid_q && on_last;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_aes_ctr_keystream_reader.sv
module tb_aes_ctr_keystream_reader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [2047:0] batch_in;
    logic          batch_valid;
    logic [127:0]  ks_data;
    logic          ks_valid;
    logic          ks_ready;
    logic [5:0]    ks_index;
    logic          ks_last;
    logic          busy;
    logic          done;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    aes_ctr_keystream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .batch_in    (batch_in),
        .batch_valid (batch_valid),
        .ks_data     (ks_data),
        .ks_valid    (ks_valid),
        .ks_ready    (ks_ready),
        .ks_index    (ks_index),
        .ks_last     (ks_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a stream is a request for N blocks; the reader holds at most one
    // batch, whose unread blocks sit in bufq in delivery order.
    logic [127:0] bufq[$];
    bit           m_busy;
    bit           m_done;
    bit           m_ovf;
    int           m_need;
    int           m_idx;

    function automatic void model_reset();
        bufq.delete();
        m_busy = 0;
        m_done = 0;
        m_ovf  = 0;
        m_need = 0;
        m_idx  = 0;
    endfunction

    always @(negedge clk) begin
        bit exp_v;
        bit fin;
        if (!rst_n) model_reset();
        exp_v = m_busy && !m_done && (bufq.size() > 0);
        check("ks_valid", ks_valid, exp_v);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
        if (exp_v) begin
            check("ks_data", ks_data, bufq[0]);
            check("ks_index", ks_index, m_idx);
            check("ks_last", ks_last, m_need == 1);
        end
        if (rst_n) begin
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_need = mode ? 8 : 44;
                    m_idx  = 0;
                    m_ovf  = 0;
                    bufq.delete();
                end
            end else begin
                fin = 0;
                if (exp_v && ks_ready) begin
                    void'(bufq.pop_front());
                    m_idx++;
                    m_need--;
                    if (m_need == 0) begin
                        m_done = 1;
                        fin    = 1;
                        bufq.delete();
                    end
                end
                if (batch_valid && !fin) begin
                    if (bufq.size() == 0) begin
                        for (int i = 0; i < 16; i++) bufq.push_back(batch_in[i*128 +: 128]);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start       = 1'b0;
        batch_valid = 1'b0;
    endtask

    task automatic pulse_batch(input bit patterned);
        if (patterned) begin
            for (int i = 0; i < 16; i++) batch_in[i*128 +: 128] = {16{8'(i)}};
        end else begin
            for (int w = 0; w < 64; w++) batch_in[w*32 +: 32] = $urandom();
        end
        batch_valid = 1'b1;
    endtask

    task automatic start_stream(input bit m);
        start = 1'b1;
        mode  = m;
        tick();
    endtask

    // ready_kind: 0 always ready, 1 pattern 1-0-0-1, 2 random.
    // eager: offer the next batch in the cycle the last buffered block is taken.
    task automatic drain(input int ready_kind, input bit eager, input int gap, input bit patterned);
        int cyc;
        int last_feed;
        cyc       = 0;
        last_feed = -100000;
        while (m_busy && cyc < 3000) begin
            case (ready_kind)
                0:       ks_ready = 1'b1;
                1:       ks_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ks_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_busy && !m_done &&
                ((bufq.size() == 0 && (cyc - last_feed) >= gap) ||
                 (eager && bufq.size() == 1 && ks_ready && m_need > 1))) begin
                pulse_batch(patterned);
                last_feed = cyc;
            end
            tick();
            cyc++;
        end
        check("stream_end_busy", busy, 1'b0);
    endtask

    initial begin
        logic [127:0] first_blk;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        batch_in    = '0;
        batch_valid = 1'b0;
        ks_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ks_valid", ks_valid, 1'b0);
        check("rst_ks_data", ks_data, 128'd0);
        check("rst_ks_index", ks_index, 6'd0);
        check("rst_ks_last", ks_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Batch while idle is discarded.
        pulse_batch(0);
        tick();
        tick();
        check("idle_batch_valid", ks_valid, 1'b0);
        check("idle_batch_ovf", overflow, 1'b0);

        // PRF with patterned batch, always ready.
        start_stream(1);
        drain(0, 0, 0, 1);

        // XOF with batches 40 cycles apart.
        start_stream(0);
        drain(0, 0, 40, 0);
        check("xof_no_ovf", overflow, 1'b0);

        // PRF under 1-0-0-1 backpressure.
        start_stream(1);
        drain(1, 0, 0, 0);

        // Overflow: second batch while the first is stalled.
        start_stream(0);
        ks_ready = 1'b0;
        pulse_batch(0);
        first_blk = batch_in[127:0];
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pulse_batch(0);
            tick();
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_index", ks_index, 6'd0);
        check("ovf_block0", ks_data, first_blk);
        drain(2, 0, 0, 0);
        check("ovf_sticky", overflow, 1'b1);
        start_stream(0);
        check("ovf_cleared", overflow, 1'b0);
        drain(0, 0, 0, 0);

        // Batch coincident with the handshake of block 15.
        start_stream(0);
        drain(0, 1, 0, 0);
        check("boundary_no_ovf", overflow, 1'b0);

        // Randomised streams.
        for (int s = 0; s < 4; s++) begin
            start_stream(1'($urandom_range(0, 1)));
            drain(2, 1'($urandom_range(0, 1)), 0, 0);
        end

        // Start while busy is ignored.
        start_stream(1);
        ks_ready = 1'b0;
        pulse_batch(0);
        tick();
        start = 1'b1;
        mode  = 1'b0;
        tick();
        drain(0, 0, 0, 0);

        // Asynchronous reset mid-drain.
        start_stream(1);
        ks_ready = 1'b0;
        pulse_batch(0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ks_valid", ks_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        start_stream(1);
        drain(0, 0, 0, 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
